sram_luma_encoder_top: RTL and testbench

Top-level board block. A push-button start launches an encode run. The run first opens a UART activity window that closes after a 1 s quiet timeout. It then converts the packed 24-bit RGB image held in external SRAM into 8-bit luma samples, written back in place from address 0. The block drives the external SRAM emulator interface, seven-segment displays and LEDs.

---
 rtl/sram_luma_encoder_top.sv | 212 +++++++++++++++++++++
 tb/tb_sram_luma_encoder_top.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_luma_encoder_top.sv
// sram_luma_encoder_top
//   Board-level encoder. A start press opens a UART activity window that
//   closes after a quiet timeout, then every packed 24-bit RGB pixel pair in
//   SRAM is turned into two 8-bit luma samples written back from word 0.
// Ports
//   CLOCK_50_I         system clock, rising edge
//   SWITCH_I[17]       synchronous active-high reset (other bits unused)
//   PUSH_BUTTON_N_I[0] active-low start (other bits unused)
//   SEVEN_SEGMENT_N_O  8 active-low digits, digits 4..0 = hex write count
//   LED_GREEN_O        [0] busy, [1] waiting on UART, [2] encoding
//   SRAM_*             external SRAM; data bus driven only while writing
//   UART_RX_I/TX_O     serial in (edges only watched), serial out idle
module sram_luma_encoder_top #(
   parameter int          no_cols      = 640,
   parameter int          no_rows      = 480,
   // quiet-window length in clock cycles (1 s at 50 MHz)
   parameter logic [25:0] uart_timeout = 26'd49_999_999
) (
   input  logic            CLOCK_50_I,
   input  logic [17:0]     SWITCH_I,
   input  logic [3:0]      PUSH_BUTTON_N_I,
   output logic [7:0][6:0] SEVEN_SEGMENT_N_O,
   output logic [8:0]      LED_GREEN_O,
   inout  wire  [15:0]     SRAM_DATA_IO,
   output logic [19:0]     SRAM_ADDRESS_O,
   output logic            SRAM_UB_N_O,
   output logic            SRAM_LB_N_O,
   output logic            SRAM_CE_N_O,
   output logic            SRAM_OE_N_O,
   output logic            SRAM_WE_N_O,
   input  logic            UART_RX_I,
   output logic            UART_TX_O
);

   localparam int          num_pairs = no_cols * no_rows / 2;
   localparam logic [19:0] last_pair = 20'(num_pairs - 1);

   typedef enum logic [1:0] {
      S_IDLE, S_ENABLE_UART_RX, S_WAIT_UART_RX, S_ENCODE
   } top_state_t;

   typedef enum logic [2:0] {
      E_RD0, E_RD1, E_RD2, E_WAIT, E_CAP, E_WR
   } enc_state_t;

   logic clk;
   logic srst;
   assign clk  = CLOCK_50_I;
   assign srst = SWITCH_I[17];

   logic unused_inputs;
   assign unused_inputs = ^{SWITCH_I[16:0], PUSH_BUTTON_N_I[3:1]};

   top_state_t  top_state, top_next;
   enc_state_t  enc_state_reg, enc_state_next;
   logic [25:0] UART_timer;
   logic [19:0] address_reg, rd_ptr_reg, pair_reg, write_count_reg;
   logic [15:0] word0_reg, word1_reg, wdata_reg;
   logic        we_n_reg;

   // Two-flop synchronizers plus one history flop for edge detection. They
   // are deliberately not reset so a button held through reset cannot fake
   // a falling edge once reset is released.
   logic [2:0] start_sync_reg, rx_sync_reg;
   logic       start_fall, rx_fall;

   always_ff @(posedge clk) begin
      start_sync_reg <= {start_sync_reg[1:0], PUSH_BUTTON_N_I[0]};
      rx_sync_reg    <= {rx_sync_reg[1:0], UART_RX_I};
   end

   assign start_fall = start_sync_reg[2] & ~start_sync_reg[1];
   assign rx_fall    = rx_sync_reg[2] & ~rx_sync_reg[1];

   function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
      logic [15:0] sum;
      // worst case 256*255+128 = 65408 still fits 16 bits
      sum = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b} + 16'd128;
      return sum[15:8];
   endfunction

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (srst) begin
         top_state     <= S_IDLE;
         enc_state_reg <= E_RD0;
      end else begin
         top_state     <= top_next;
         enc_state_reg <= enc_state_next;
      end
   end

   always_comb begin
      top_next       = top_state;
      enc_state_next = enc_state_reg;
      case (top_state)
         S_IDLE:           if (start_fall) top_next = S_ENABLE_UART_RX;
         S_ENABLE_UART_RX: top_next = S_WAIT_UART_RX;
         S_WAIT_UART_RX: begin
            if (UART_timer == uart_timeout) begin
               top_next       = S_ENCODE;
               enc_state_next = E_RD0;
            end
         end
         S_ENCODE: begin
            case (enc_state_reg)
               E_RD0:  enc_state_next = E_RD1;
               E_RD1:  enc_state_next = E_RD2;
               E_RD2:  enc_state_next = E_WAIT;
               E_WAIT: enc_state_next = E_CAP;
               E_CAP:  enc_state_next = E_WR;
               E_WR: begin
                  enc_state_next = E_RD0;
                  if (pair_reg == last_pair) top_next = S_IDLE;
               end
               default: enc_state_next = E_RD0;
            endcase
         end
         default: top_next = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // Reads land two cycles after their address: word 3k is captured at the
   // end of RD2, 3k+1 at the end of WAIT, and 3k+2 is used live at the end
   // of CAP to build the write word, so the write goes out in WR.
   always_ff @(posedge clk) begin
      if (srst) begin
         UART_timer      <= '0;
         address_reg     <= '0;
         rd_ptr_reg      <= '0;
         pair_reg        <= '0;
         write_count_reg <= '0;
         word0_reg       <= '0;
         word1_reg       <= '0;
         wdata_reg       <= '0;
         we_n_reg        <= 1'b1;
      end else begin
         we_n_reg <= 1'b1;
         case (top_state)
            S_IDLE: if (start_fall) write_count_reg <= '0;
            S_ENABLE_UART_RX: UART_timer <= '0;
            S_WAIT_UART_RX: begin
               if (rx_fall) UART_timer <= '0;
               else         UART_timer <= UART_timer + 26'd1;
               if (UART_timer == uart_timeout) begin
                  address_reg <= '0;
                  rd_ptr_reg  <= '0;
                  pair_reg    <= '0;
               end
            end
            S_ENCODE: begin
               case (enc_state_reg)
                  E_RD0, E_RD1: address_reg <= address_reg + 20'd1;
                  E_RD2:        word0_reg   <= SRAM_DATA_IO;
                  E_WAIT:       word1_reg   <= SRAM_DATA_IO;
                  E_CAP: begin
                     address_reg <= pair_reg;
                     we_n_reg    <= 1'b0;
                     // {R0,G0} {B0,R1} {G1,B1}; even pixel goes to [15:8]
                     wdata_reg   <= {luma(word0_reg[15:8], word0_reg[7:0], word1_reg[15:8]),
                                     luma(word1_reg[7:0], SRAM_DATA_IO[15:8], SRAM_DATA_IO[7:0])};
                  end
                  E_WR: begin
                     address_reg     <= rd_ptr_reg + 20'd3;
                     rd_ptr_reg      <= rd_ptr_reg + 20'd3;
                     pair_reg        <= pair_reg + 20'd1;
                     write_count_reg <= write_count_reg + 20'd1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign SRAM_DATA_IO   = we_n_reg ? 16'hzzzz : wdata_reg;
   assign SRAM_ADDRESS_O = address_reg;
   assign SRAM_WE_N_O    = we_n_reg;
   assign SRAM_UB_N_O    = 1'b0;
   assign SRAM_LB_N_O    = 1'b0;
   assign SRAM_CE_N_O    = 1'b0;
   assign SRAM_OE_N_O    = 1'b0;
   assign UART_TX_O      = 1'b1;

   assign LED_GREEN_O = {6'd0, top_state == S_ENCODE, top_state == S_WAIT_UART_RX,
                         top_state != S_IDLE};

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_digit
         if (gi < 5) begin : g_hex
            assign SEVEN_SEGMENT_N_O[gi] = hex_to_seg(write_count_reg[4*gi +: 4]);
         end else begin : g_blank
            assign SEVEN_SEGMENT_N_O[gi] = 7'h7F;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sram_luma_encoder_top.sv
// Directed bench for sram_luma_encoder_top on a reduced 12x5 image with a
// shortened UART quiet window; includes a behavioural SRAM with two-cycle
// read latency.
module tb_sram_luma_encoder_top;

   localparam int          cols    = 12;
   localparam int          rows    = 5;
   localparam int          pairs   = cols * rows / 2;   // 30 = 0x1E
   localparam logic [25:0] timeout = 26'd30;

   logic            clk = 1'b0;
   logic [17:0]     sw;
   logic [3:0]      btn;
   logic            rx;
   logic [7:0][6:0] seg;
   logic [8:0]      led;
   wire  [15:0]     sram_data;
   logic [19:0]     addr;
   logic            ub_n, lb_n, ce_n, oe_n, we_n, tx;

   always #10 clk = ~clk;

   sram_luma_encoder_top #(.no_cols(cols), .no_rows(rows), .uart_timeout(timeout)) dut (
      .CLOCK_50_I(clk), .SWITCH_I(sw), .PUSH_BUTTON_N_I(btn),
      .SEVEN_SEGMENT_N_O(seg), .LED_GREEN_O(led), .SRAM_DATA_IO(sram_data),
      .SRAM_ADDRESS_O(addr), .SRAM_UB_N_O(ub_n), .SRAM_LB_N_O(lb_n),
      .SRAM_CE_N_O(ce_n), .SRAM_OE_N_O(oe_n), .SRAM_WE_N_O(we_n),
      .UART_RX_I(rx), .UART_TX_O(tx)
   );

   // ---------------- SRAM model ----------------
   logic [15:0] mem      [0:255];
   logic [15:0] init_mem [0:255];
   logic [19:0] wr_log   [0:255];
   logic [19:0] a1 = '0, a2 = '0;
   logic        load_en = 1'b0;
   int          total_writes = 0;

   always @(posedge clk) begin
      a1 <= addr;
      a2 <= a1;
      if (load_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
      end else if (!we_n) begin
         mem[addr[7:0]]              <= sram_data;
         wr_log[total_writes[7:0]]   <= addr;
         total_writes                <= total_writes + 1;
      end
   end

   assign sram_data = we_n ? mem[a2[7:0]] : 16'hzzzz;

   // ---------------- checking ----------------
   int num_checks = 0;
   int num_fail   = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pair(input int k, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2);
      init_mem[3*k]   = w0;
      init_mem[3*k+1] = w1;
      init_mem[3*k+2] = w2;
   endtask

   task automatic load_sram();
      load_en = 1'b1;
      step(1);
      load_en = 1'b0;
   endtask

   task automatic wait_encode_start(input int limit);
      int n = 0;
      while (!led[2] && n < limit) begin
         step(1);
         n++;
      end
   endtask

   // counts encode cycles starting from the first cycle seen in S_ENCODE
   task automatic wait_encode_end(output int cycles);
      cycles = 1;
      while (led[2] && cycles < 2000) begin
         step(1);
         if (led[2]) cycles++;
      end
   endtask

   task automatic wait_timer(input logic [25:0] value);
      int n = 0;
      while (dut.UART_timer != value && n < 200) begin
         step(1);
         n++;
      end
   endtask

   int edges, cycles, w0;

   initial begin
      sw  = 18'h20000;
      btn = 4'hF;
      rx  = 1'b1;
      for (int i = 0; i < 256; i++) init_mem[i] = (i >= 90) ? (16'hC000 + 16'(i)) : 16'h0000;
      set_pair(0,  16'hFFFF, 16'hFFFF, 16'hFFFF);   // white      -> FFFF
      set_pair(1,  16'h0000, 16'h0000, 16'h0000);   // black      -> 0000
      set_pair(2,  16'hFF00, 16'h0000, 16'hFF00);   // red, green -> 4D95
      set_pair(3,  16'h0000, 16'hFF00, 16'h00FF);   // blue, blue -> 1D1D
      set_pair(4,  16'h8080, 16'h8080, 16'h8080);   // grey       -> 8080
      set_pair(5,  16'h1020, 16'h3040, 16'h5060);   // mixed      -> 1D4D
      set_pair(6,  16'h0100, 16'h0000, 16'h0100);   // rounding   -> 0001
      set_pair(10, 16'h1020, 16'h3040, 16'h5060);   // mixed      -> 1D4D
      set_pair(29, 16'hFFFF, 16'hFFFF, 16'hFFFF);   // last pair  -> FFFF

      // reset held three cycles (SRAM preload happens during the first)
      load_sram();
      step(2);
      check_value("reset_led", led, 9'h000);
      check_value("reset_we_n", we_n, 1'b1);
      check_value("reset_state", 32'(dut.top_state), 0);
      check_value("reset_tx", tx, 1'b1);
      check_value("reset_addr", addr, 20'h0);
      check_value("reset_digit0", seg[0], 7'h40);
      check_value("reset_digit7", seg[7], 7'h7F);

      sw = '0;
      step(2);
      check_value("idle_led", led, 9'h000);

      // start press: two sync flops plus edge detect
      btn[0] = 1'b0;
      edges  = 0;
      while (!led[0] && edges < 6) begin
         step(1);
         edges++;
      end
      check_value("start_within_3", (edges >= 1 && edges <= 3), 1'b1);
      check_value("enable_uart_led", led, 9'h001);
      step(1);
      check_value("wait_uart_led", led, 9'h003);
      check_value("timer_cleared", dut.UART_timer, 26'd0);

      // a falling edge on the serial line restarts the quiet window
      wait_timer(26'd15);
      check_value("timer_reached_15", dut.UART_timer, 26'd15);
      rx = 1'b0;
      step(4);
      check_value("rx_edge_clears_timer", (dut.UART_timer < 26'd4), 1'b1);
      rx = 1'b1;
      check_value("still_waiting", led, 9'h003);

      // timeout-9 -> timeout after 9 cycles, encode on the following edge
      wait_timer(timeout - 26'd9);
      step(9);
      check_value("timer_at_timeout", dut.UART_timer, timeout);
      check_value("wait_before_encode", led, 9'h003);
      step(1);
      check_value("encode_led", led, 9'h005);

      // full run
      w0 = total_writes;
      wait_encode_end(cycles);
      check_value("encode_cycles", cycles, 6 * pairs);
      check_value("write_count", total_writes - w0, pairs);
      check_value("first_write_addr", wr_log[w0[7:0]], 20'd0);
      check_value("last_write_addr", wr_log[8'(w0 + pairs - 1)], 20'(pairs - 1));
      check_value("done_led", led, 9'h000);
      check_value("digit0_E", seg[0], 7'h06);
      check_value("digit1_1", seg[1], 7'h79);
      check_value("digit2_0", seg[2], 7'h40);
      check_value("digit4_0", seg[4], 7'h40);
      check_value("digit5_blank", seg[5], 7'h7F);
      check_value("y_white", mem[0], 16'hFFFF);
      check_value("y_black", mem[1], 16'h0000);
      check_value("y_red_green", mem[2], 16'h4D95);
      check_value("y_blue", mem[3], 16'h1D1D);
      check_value("y_grey", mem[4], 16'h8080);
      check_value("y_mixed", mem[5], 16'h1D4D);
      check_value("y_rounding", mem[6], 16'h0001);
      check_value("y_mixed_10", mem[10], 16'h1D4D);
      check_value("y_zero_28", mem[28], 16'h0000);
      check_value("y_last", mem[29], 16'hFFFF);
      check_value("input_30_kept", mem[30], 16'h1020);
      check_value("input_89_kept", mem[89], 16'hFFFF);
      check_value("beyond_90_kept", mem[90], 16'hC05A);
      check_value("beyond_100_kept", mem[100], 16'hC064);

      // button still held low: no new run
      step(6);
      check_value("no_retrigger", led, 9'h000);

      // reset in the middle of a run
      btn[0] = 1'b1;
      step(3);
      load_sram();
      btn[0] = 1'b0;
      wait_encode_start(200);
      check_value("abort_run_started", led, 9'h005);
      w0 = total_writes;
      step(20);
      sw[17] = 1'b1;
      step(1);
      check_value("abort_led", led, 9'h000);
      check_value("abort_state", 32'(dut.top_state), 0);
      check_value("abort_we_n", we_n, 1'b1);
      check_value("abort_digit0", seg[0], 7'h40);
      step(2);
      check_value("abort_writes", total_writes - w0, 3);
      sw[17] = 1'b0;
      step(5);
      check_value("abort_no_more_writes", total_writes - w0, 3);
      check_value("abort_stays_idle", led, 9'h000);

      // fresh start after the abort
      btn[0] = 1'b1;
      step(3);
      load_sram();
      btn[0] = 1'b0;
      wait_encode_start(200);
      w0 = total_writes;
      wait_encode_end(cycles);
      check_value("rerun_cycles", cycles, 6 * pairs);
      check_value("rerun_writes", total_writes - w0, pairs);
      check_value("rerun_first_addr", wr_log[w0[7:0]], 20'd0);
      check_value("rerun_y_red_green", mem[2], 16'h4D95);
      check_value("rerun_y_mixed", mem[5], 16'h1D4D);
      check_value("rerun_digit0", seg[0], 7'h06);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
